// File: rtl/egress_switch_pkg.sv
// Shared types for the egress switch: dest strobe, queue entry,
// packet word and egress FSM state.
package egress_switch_pkg;

  localparam int NUM_EGRESS_PORTS = 4;
  localparam int PORT_W = 2;
  localparam int WORD_W = 16;

  typedef struct packed {
    logic [PORT_W-1:0] tdata;
    logic              tvalid;
    logic              tuser;
  } dest_source_t;

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DROP
  } egress_state_t;

  typedef struct packed {
    logic              invalid;
    logic [PORT_W-1:0] port;
  } dest_entry_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } pkt_word_t;

  function automatic logic [NUM_EGRESS_PORTS-1:0]
      port_onehot(input logic [PORT_W-1:0] p);
    return NUM_EGRESS_PORTS'(1) << p;
  endfunction

endpackage

// File: rtl/egress_switch_fifo.sv
// pf_sync_fifo: synchronous FIFO, async active-low reset, head shown
// as soon as written. Ports: wr_en/wr_data, rd_en/rd_data, full, empty.
module pf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  // Extra MSB separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Storage is not reset; mask the head so an empty FIFO reads zero.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/egress_switch.sv
// Egress switch: buffers packets, routes each to one of four ports or
// drops it. Ports: in_* ingress, dest strobe, out_* egress, dest_ovf,
// drop_cnt/fwd_cnt (live only with EGRESS_SWITCH_STATS_EN defined).
module egress_switch
  import egress_switch_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DEST_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           in_tdata,
  input  logic                        in_tvalid,
  input  logic                        in_tlast,
  output logic                        in_tready,
  input  dest_source_t                dest,
  output logic [WORD_W-1:0]           out_tdata,
  output logic                        out_tlast,
  output logic [NUM_EGRESS_PORTS-1:0] out_tvalid,
  input  logic [NUM_EGRESS_PORTS-1:0] out_tready,
  output logic                        dest_ovf,
  output logic [15:0]                 drop_cnt,
  output logic [15:0]                 fwd_cnt
);

  egress_state_t state, state_nx;

  pkt_word_t   pkt_in, pkt_head;
  logic        pkt_full, pkt_empty, pkt_rd;
  dest_entry_t dq_in, dq_head;
  logic        dq_full, dq_empty, dq_rd;
  logic        rdy_q;
  logic [PORT_W-1:0] port_q;
  logic        fwd_inc, drop_inc;

  // Holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign in_tready = rdy_q && !pkt_full;

  assign pkt_in = '{last: in_tlast, data: in_tdata};
  assign dq_in  = '{invalid: dest.tuser, port: dest.tdata};

  pf_sync_fifo #(
    .WIDTH($bits(pkt_word_t)),
    .DEPTH(DEPTH)
  ) u_pkt_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (in_tvalid && in_tready),
    .wr_data(pkt_in),
    .rd_en  (pkt_rd),
    .rd_data(pkt_head),
    .full   (pkt_full),
    .empty  (pkt_empty)
  );

  pf_sync_fifo #(
    .WIDTH($bits(dest_entry_t)),
    .DEPTH(DEST_DEPTH)
  ) u_dest_q (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (dest.tvalid),
    .wr_data(dq_in),
    .rd_en  (dq_rd),
    .rd_data(dq_head),
    .full   (dq_full),
    .empty  (dq_empty)
  );

  assign out_tdata = pkt_head.data;
  assign out_tlast = pkt_head.last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dest_ovf <= 1'b0;
    else if (dest.tvalid && dq_full) dest_ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      port_q <= '0;
    end else begin
      state <= state_nx;
      if (dq_rd) port_q <= dq_head.port;
    end
  end

  always_comb begin
    state_nx   = state;
    dq_rd      = 1'b0;
    pkt_rd     = 1'b0;
    out_tvalid = '0;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!dq_empty) begin
          dq_rd    = 1'b1;
          state_nx = dq_head.invalid ? DROP : FORWARD;
        end
      end
      FORWARD: begin
        if (!pkt_empty) begin
          out_tvalid = port_onehot(port_q);
          pkt_rd     = out_tready[port_q];
        end
        if (pkt_rd && pkt_head.last) begin
          fwd_inc  = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: begin
        pkt_rd = !pkt_empty;
        if (pkt_rd && pkt_head.last) begin
          drop_inc = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef EGRESS_SWITCH_STATS_EN
  logic [15:0] fwd_q, drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_q  <= '0;
      drop_q <= '0;
    end else begin
      if (fwd_inc && fwd_q != 16'hFFFF)
        fwd_q <= fwd_q + 16'd1;
      if (drop_inc && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign fwd_cnt  = fwd_q;
  assign drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats = fwd_inc ^ drop_inc;
  assign fwd_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule
